fpmul_rr_scheduler: RTL and testbench
=====================================

Name: fpmul_rr_scheduler

Overview:
- Shares one single-precision FP multiply datapath (the product unit plus its pipeline registers) among N requesters.
- Arbitration is round-robin; at most one issue per cycle.
- Tracks in-flight operations through a valid/ID shift pipeline matched to the multiplier latency.
- Returns each result and its U/O flags to a per-requester result slot, held until acknowledged.
- Sits between the operand producers and the shared product unit.

Parameters:
- N, 4: number of requesters (2..8).
- MUL_LAT, 2: register stages inside the multiplier path between mul_a/mul_b and mul_result (0 = combinational).
- IDW, 2: width of grant_id; must equal clog2(N).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- en  in  1  issue enable; low blocks new grants only
- req_valid  in  N  requester i has operands
- req_ready  out  N  one-hot grant; issue on req_valid[i]&req_ready[i]
- req_a  in  N*32  operand A per requester, slice i = [32i+31:32i]
- req_b  in  N*32  operand B per requester
- mul_valid  out  1  registered; operands on mul_a/mul_b valid
- mul_a  out  32  registered operand A to multiplier
- mul_b  out  32  registered operand B to multiplier
- mul_result  in  32  multiplier result, MUL_LAT cycles after mul_valid
- mul_u  in  1  underflow flag, aligned with mul_result
- mul_o  in  1  overflow flag, aligned with mul_result
- rsp_valid  out  N  result slot i holds a result
- rsp_data  out  N*32  result per requester
- rsp_u  out  N  underflow per requester
- rsp_o  out  N  overflow per requester
- rsp_ack  in  N  consume slot i
- busy  out  1  any requester not IDLE or any stage in flight
- grant_id  out  IDW  index of last granted requester (registered)

Behaviour:
- Reset (rst_n low at a clk edge):
  - all outputs 0; all slots IDLE; rr pointer 0; pipeline valids cleared.
  - In-flight operations are discarded; no rsp_valid results from them after reset.
- Per-requester FSM, 3 states:
  - IDLE -> INFLIGHT on grant.
  - INFLIGHT -> DONE when its ID exits the pipeline.
  - DONE -> IDLE on rsp_ack[i].
- Eligibility: i is eligible iff en & req_valid[i] & state[i]==IDLE. This guarantees no slot overwrite and no result loss.
- Arbitration (combinational, same cycle):
  - Search eligible requesters starting at rr pointer, wrapping mod N.
  - First eligible one gets req_ready[i]=1. At most one bit set; none if no requester is eligible.
  - req_ready never depends on the granted requester's own req_a/req_b.
- Grant at cycle T, at the edge ending T:
  - mul_a/mul_b <= req_a/req_b slice i; mul_valid <= 1.
  - tag {1,i} enters the ID pipeline.
  - grant_id <= i; rr pointer <= (i+1) mod N.
- No grant at cycle T: mul_valid <= 0, tag valid <= 0, mul_a/mul_b hold, pointer holds.
- ID pipeline: MUL_LAT+1 stages total (the issue stage plus MUL_LAT delay stages). It exits aligned with mul_result.
- Capture: at the edge ending cycle T+1+MUL_LAT:
  - rsp_data[i] <= mul_result; rsp_u[i] <= mul_u; rsp_o[i] <= mul_o.
  - state -> DONE.
  - rsp_valid[i]=1 from cycle T+2+MUL_LAT.
- Latency: grant to rsp_valid = MUL_LAT+2 cycles. Throughput: 1 issue/cycle across distinct requesters. A single requester is limited to one outstanding operation.
- Response hold:
  - rsp_valid[i], rsp_data, and flags are stable until the rsp_ack[i] edge.
  - Slot clears on that edge; requester i is eligible the following cycle.
  - rsp_ack[i] while not DONE is ignored.
- en low: no grants; in-flight operations complete and capture normally; slots wait for ack.
- Simultaneous events: capture for requester j and grant for requester k on the same edge are independent. The same requester cannot be both (INFLIGHT is not eligible).
- Flags and special values (zero, NaN, inf) pass through unchanged; the scheduler never inspects data.
- busy = |(state != IDLE) | any pipeline valid.

Test Plan:
- Single op, MUL_LAT=2: req_valid[0], a=0x3FC00000 (1.5), b=0x40000000 (2.0) at cycle 0 -> req_ready=0001 in cycle 0, mul_valid in cycle 1, rsp_valid[0] in cycle 4 with rsp_data=0x40400000, U=O=0; rsp_ack clears it the next cycle.
- All 4 requesters valid from reset -> grants in order 0,1,2,3 on consecutive cycles; mul_valid high 4 consecutive cycles; rsp_valid bits rise in cycles 4,5,6,7.
- Fairness: req 1 and 3 held valid continuously with immediate acks -> grants alternate 1,3,1,3; neither is granted twice in a row while the other is eligible.
- Backpressure: requester 2 completes, no ack for 10 cycles with req_valid[2] held -> req_ready[2]=0 throughout, rsp_data stable; ack at cycle k -> regrant at cycle k+1.
- en low with 2 ops in flight -> both complete and set rsp_valid; no new req_ready until en returns.
- rst_n low 1 cycle while 3 ops in flight -> next cycle all rsp_valid=0, busy=0, mul_valid=0, rr pointer 0; stale mul_result not captured.

Source files
------------

// File: rtl/fpmul_rr_scheduler.sv
// Round-robin scheduler sharing one pipelined single-precision multiplier among N requesters.
// Each requester owns a single result slot that holds its product and U/O flags until acknowledged.
module fpmul_rr_scheduler #(
    parameter int N       = 4,
    parameter int MUL_LAT = 2,
    parameter int IDW     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [N-1:0]      req_valid,
    output logic [N-1:0]      req_ready,
    input  logic [N*32-1:0]   req_a,
    input  logic [N*32-1:0]   req_b,
    output logic              mul_valid,
    output logic [31:0]       mul_a,
    output logic [31:0]       mul_b,
    input  logic [31:0]       mul_result,
    input  logic              mul_u,
    input  logic              mul_o,
    output logic [N-1:0]      rsp_valid,
    output logic [N*32-1:0]   rsp_data,
    output logic [N-1:0]      rsp_u,
    output logic [N-1:0]      rsp_o,
    input  logic [N-1:0]      rsp_ack,
    output logic              busy,
    output logic [IDW-1:0]    grant_id
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_INFLIGHT = 2'd1,
        ST_DONE     = 2'd2
    } state_e;

    state_e              state_r [N];
    logic [IDW-1:0]      rr_r;
    logic [IDW-1:0]      grant_id_r;
    logic                mul_valid_r;
    logic [31:0]         mul_a_r;
    logic [31:0]         mul_b_r;
    logic                pipe_v_r  [MUL_LAT+1];
    logic [IDW-1:0]      pipe_id_r [MUL_LAT+1];
    logic [N-1:0]        rsp_valid_r;
    logic [N*32-1:0]     rsp_data_r;
    logic [N-1:0]        rsp_u_r;
    logic [N-1:0]        rsp_o_r;

    logic [N-1:0]        elig_s;
    logic [N-1:0]        req_ready_s;
    logic                grant_v_s;
    logic [IDW-1:0]      grant_idx_s;
    logic [IDW:0]        sum_s;
    logic [IDW-1:0]      cand_s;
    logic [31:0]         sel_a_s;
    logic [31:0]         sel_b_s;
    logic                cap_v_s;
    logic [IDW-1:0]      cap_id_s;
    logic                busy_s;

    // Only idle slots may be granted, so a pending result is never overwritten.
    always_comb begin
        elig_s = '0;
        for (int i = 0; i < N; i++) begin
            elig_s[i] = rst_n & en & req_valid[i] & (state_r[i] == ST_IDLE);
        end
    end

    // Round-robin search starting at the pointer, wrapping mod N.
    always_comb begin
        grant_v_s   = 1'b0;
        grant_idx_s = '0;
        req_ready_s = '0;
        sum_s       = '0;
        cand_s      = '0;
        for (int off = 0; off < N; off++) begin
            sum_s = {1'b0, rr_r} + (IDW+1)'(off);
            if (sum_s >= (IDW+1)'(N)) begin
                cand_s = IDW'(sum_s - (IDW+1)'(N));
            end else begin
                cand_s = sum_s[IDW-1:0];
            end
            if (!grant_v_s && elig_s[cand_s]) begin
                grant_v_s   = 1'b1;
                grant_idx_s = cand_s;
            end else begin
                grant_v_s   = grant_v_s;
            end
        end
        if (grant_v_s) begin
            req_ready_s[grant_idx_s] = 1'b1;
        end else begin
            req_ready_s = '0;
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_a_s = '0;
        sel_b_s = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx_s == IDW'(i)) begin
                sel_a_s = req_a[i*32 +: 32];
                sel_b_s = req_b[i*32 +: 32];
            end else begin
                sel_a_s = sel_a_s;
                sel_b_s = sel_b_s;
            end
        end
    end

    assign cap_v_s  = pipe_v_r[MUL_LAT];
    assign cap_id_s = pipe_id_r[MUL_LAT];

    // Issue registers, tag pipeline, per-requester slot FSMs and result capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mul_valid_r <= 1'b0;
            mul_a_r     <= 32'd0;
            mul_b_r     <= 32'd0;
            grant_id_r  <= '0;
            rr_r        <= '0;
            for (int k = 0; k <= MUL_LAT; k++) begin
                pipe_v_r[k]  <= 1'b0;
                pipe_id_r[k] <= '0;
            end
            for (int i = 0; i < N; i++) begin
                state_r[i] <= ST_IDLE;
            end
            rsp_valid_r <= '0;
            rsp_data_r  <= '0;
            rsp_u_r     <= '0;
            rsp_o_r     <= '0;
        end else begin
            mul_valid_r  <= grant_v_s;
            pipe_v_r[0]  <= grant_v_s;
            pipe_id_r[0] <= grant_idx_s;
            if (grant_v_s) begin
                mul_a_r    <= sel_a_s;
                mul_b_r    <= sel_b_s;
                grant_id_r <= grant_idx_s;
                if (grant_idx_s == IDW'(N-1)) begin
                    rr_r <= '0;
                end else begin
                    rr_r <= grant_idx_s + IDW'(1);
                end
            end
            for (int k = 1; k <= MUL_LAT; k++) begin
                pipe_v_r[k]  <= pipe_v_r[k-1];
                pipe_id_r[k] <= pipe_id_r[k-1];
            end
            for (int i = 0; i < N; i++) begin
                case (state_r[i])
                    ST_IDLE: begin
                        if (grant_v_s && (grant_idx_s == IDW'(i))) begin
                            state_r[i] <= ST_INFLIGHT;
                        end
                    end
                    ST_INFLIGHT: begin
                        if (cap_v_s && (cap_id_s == IDW'(i))) begin
                            state_r[i]              <= ST_DONE;
                            rsp_valid_r[i]          <= 1'b1;
                            rsp_data_r[i*32 +: 32]  <= mul_result;
                            rsp_u_r[i]              <= mul_u;
                            rsp_o_r[i]              <= mul_o;
                        end
                    end
                    ST_DONE: begin
                        if (rsp_ack[i]) begin
                            state_r[i]     <= ST_IDLE;
                            rsp_valid_r[i] <= 1'b0;
                        end
                    end
                    default: begin
                        state_r[i]     <= ST_IDLE;
                        rsp_valid_r[i] <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Activity indicator: any occupied slot or any tag still travelling.
    always_comb begin
        busy_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            busy_s = busy_s | (state_r[i] != ST_IDLE);
        end
        for (int k = 0; k <= MUL_LAT; k++) begin
            busy_s = busy_s | pipe_v_r[k];
        end
    end

    assign req_ready = req_ready_s;
    assign mul_valid = mul_valid_r;
    assign mul_a     = mul_a_r;
    assign mul_b     = mul_b_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_u     = rsp_u_r;
    assign rsp_o     = rsp_o_r;
    assign busy      = busy_s;
    assign grant_id  = grant_id_r;

endmodule

// File: tb/tb_fpmul_rr_scheduler.sv
// Randomized scoreboard bench for fpmul_rr_scheduler with a pipelined multiplier stub.
`timescale 1ns/1ps
module tb_fpmul_rr_scheduler;
    localparam int N       = 4;
    localparam int MUL_LAT = 2;
    localparam int IDW     = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*32-1:0]   req_a;
    logic [N*32-1:0]   req_b;
    logic              mul_valid;
    logic [31:0]       mul_a;
    logic [31:0]       mul_b;
    logic [31:0]       mul_result;
    logic              mul_u;
    logic              mul_o;
    logic [N-1:0]      rsp_valid;
    logic [N*32-1:0]   rsp_data;
    logic [N-1:0]      rsp_u;
    logic [N-1:0]      rsp_o;
    logic [N-1:0]      rsp_ack;
    logic              busy;
    logic [IDW-1:0]    grant_id;

    fpmul_rr_scheduler #(.N(N), .MUL_LAT(MUL_LAT), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b),
        .mul_result(mul_result), .mul_u(mul_u), .mul_o(mul_o),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_u(rsp_u), .rsp_o(rsp_o),
        .rsp_ack(rsp_ack), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Truncating FP multiply for normal operands; returns {u, o, result}.
    function automatic logic [33:0] fp_mul_ref(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          e;
        logic [47:0] p;
        logic [22:0] m;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {2'b00, s, 31'd0};
        if (a[30:23] == 8'hff || b[30:23] == 8'hff) return {2'b00, s, 8'hff, 23'd0};
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 1;
        end else begin
            m = p[45:23];
        end
        if (e >= 255) return {2'b01, s, 8'hff, 23'd0};
        if (e <= 0) return {2'b10, s, 31'd0};
        return {2'b00, s, e[7:0], m};
    endfunction

    // Multiplier stub: MUL_LAT register stages after mul_a/mul_b.
    logic [33:0] mstage [MUL_LAT];
    always @(posedge clk) begin
        mstage[0] <= fp_mul_ref(mul_a, mul_b);
        for (int k = 1; k < MUL_LAT; k++) mstage[k] <= mstage[k-1];
    end
    assign {mul_u, mul_o, mul_result} = mstage[MUL_LAT-1];

    typedef struct {
        int          idx;
        logic [31:0] d;
        logic        u;
        logic        o;
        int          cyc;
    } exp_t;
    exp_t sb_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state: outstanding ops per requester and the rr pointer.
    logic [N-1:0] owed;
    int           done_c [N];
    int           ptr;
    int           last_gid;
    bit           prev_gv;
    logic [31:0]  prev_a;
    logic [31:0]  prev_b;

    task automatic step(input logic [N-1:0] v, input logic e, input logic [N-1:0] ack,
                        input bit rst, input bit directed);
        int           g;
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_rv;
        logic [33:0]  r;
        @(posedge clk);
        #1;
        rst_n     = !rst;
        en        = e;
        req_valid = v;
        rsp_ack   = ack;
        for (int i = 0; i < N; i++) begin
            req_a[i*32 +: 32] = $urandom;
            req_b[i*32 +: 32] = $urandom;
        end
        if (directed) begin
            req_a[31:0] = 32'h3FC00000;
            req_b[31:0] = 32'h40000000;
        end
        #2;
        if (rst) begin
            chk("req_ready_in_reset", req_ready, '0);
            owed     = '0;
            ptr      = 0;
            last_gid = 0;
            prev_gv  = 0;
            sb_q.delete();
        end else begin
            g = -1;
            for (int off = 0; off < N; off++) begin
                int c;
                c = (ptr + off) % N;
                if (g < 0 && e && v[c] && !owed[c]) g = c;
            end
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            chk("req_ready", req_ready, exp_ready);
            chk("mul_valid", mul_valid, prev_gv);
            if (prev_gv) begin
                chk("mul_a", mul_a, prev_a);
                chk("mul_b", mul_b, prev_b);
            end
            chk("grant_id", grant_id, last_gid);
            for (int i = 0; i < N; i++) exp_rv[i] = owed[i] && (cyc >= done_c[i]);
            chk("rsp_valid", rsp_valid, exp_rv);
            chk("busy", busy, |owed);
            for (int i = 0; i < N; i++) if (ack[i] && exp_rv[i]) owed[i] = 1'b0;
            if (g >= 0) begin
                r = fp_mul_ref(req_a[g*32 +: 32], req_b[g*32 +: 32]);
                sb_q.push_back('{idx: g, d: r[31:0], u: r[33], o: r[32], cyc: cyc});
                owed[g]   = 1'b1;
                done_c[g] = cyc + MUL_LAT + 2;
                ptr       = (g + 1) % N;
                last_gid  = g;
                prev_gv   = 1;
                prev_a    = req_a[g*32 +: 32];
                prev_b    = req_b[g*32 +: 32];
            end else begin
                prev_gv = 0;
            end
        end
    endtask

    // Monitor: pops the scoreboard whenever a result slot becomes valid.
    logic [N-1:0] prev_rv = '0;
    logic [31:0]  held [N];
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                for (int i = 0; i < N; i++) begin
                    if (rsp_valid[i] && !prev_rv[i]) begin
                        int k;
                        k = -1;
                        for (int j = 0; j < sb_q.size(); j++) if (k < 0 && sb_q[j].idx == i) k = j;
                        if (k < 0) begin
                            tests++;
                            fails++;
                            $display("FAIL rsp_unexpected: slot %0d got %0h expected none (cycle %0d)",
                                     i, rsp_data[i*32 +: 32], cyc);
                        end else begin
                            chk("rsp_data", rsp_data[i*32 +: 32], sb_q[k].d);
                            chk("rsp_u", rsp_u[i], sb_q[k].u);
                            chk("rsp_o", rsp_o[i], sb_q[k].o);
                            chk("latency", cyc - sb_q[k].cyc, MUL_LAT + 2);
                            sb_q.delete(k);
                            held[i] = rsp_data[i*32 +: 32];
                        end
                    end else if (rsp_valid[i] && prev_rv[i]) begin
                        chk("rsp_hold", rsp_data[i*32 +: 32], held[i]);
                    end
                end
            end
            prev_rv = rsp_valid;
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; req_valid = '0; rsp_ack = '0; req_a = '0; req_b = '0;
        owed = '0; ptr = 0; last_gid = 0; prev_gv = 0;
        step('0, 1'b0, '0, 1, 0);
        step('0, 1'b0, '0, 1, 0);

        // Directed 1.5 * 2.0 on requester 0, held unacknowledged.
        step(4'b0001, 1'b1, '0, 0, 1);
        repeat (5) step('0, 1'b1, '0, 0, 0);
        chk("directed_valid", rsp_valid[0], 1'b1);
        chk("directed_data", rsp_data[31:0], 32'h40400000);
        chk("directed_flags", {rsp_u[0], rsp_o[0]}, 2'b00);
        step('0, 1'b1, 4'b0001, 0, 0);
        step('0, 1'b1, '0, 0, 0);

        // All requesters, immediate acks.
        repeat (16) step(4'b1111, 1'b1, 4'b1111, 0, 0);
        repeat (8) step('0, 1'b1, 4'b1111, 0, 0);

        // Fairness between requesters 1 and 3.
        repeat (24) step(4'b1010, 1'b1, 4'b1111, 0, 0);
        repeat (8) step('0, 1'b1, 4'b1111, 0, 0);

        // Backpressure on requester 2.
        repeat (15) step(4'b0100, 1'b1, '0, 0, 0);
        step(4'b0100, 1'b1, 4'b0100, 0, 0);
        repeat (3) step(4'b0100, 1'b1, '0, 0, 0);
        repeat (8) step('0, 1'b1, 4'b1111, 0, 0);

        // en low with two operations in flight.
        step(4'b0011, 1'b1, '0, 0, 0);
        step(4'b0011, 1'b1, '0, 0, 0);
        repeat (8) step(4'b0011, 1'b0, '0, 0, 0);
        repeat (3) step(4'b0011, 1'b0, 4'b1111, 0, 0);
        repeat (4) step(4'b0011, 1'b1, 4'b1111, 0, 0);
        repeat (8) step('0, 1'b1, 4'b1111, 0, 0);

        // Random traffic, including acks to non-done slots.
        repeat (400) step(N'($urandom), ($urandom_range(0, 7) != 0), N'($urandom), 0, 0);
        repeat (10) step('0, 1'b1, 4'b1111, 0, 0);
        chk("scoreboard_drained", sb_q.size(), 0);

        // Reset while three operations are in flight.
        repeat (3) step(4'b1111, 1'b1, '0, 0, 0);
        step(4'b1111, 1'b1, '0, 1, 0);
        repeat (6) step('0, 1'b1, '0, 0, 0);
        repeat (6) step(4'b1111, 1'b1, 4'b1111, 0, 0);
        repeat (8) step('0, 1'b1, 4'b1111, 0, 0);
        chk("scoreboard_final", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
